// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op/state encodings and lane width for alu_seq
package alu_seq_pkg;
  localparam int LANE_W = 8;
  typedef enum logic [2:0] {
    OP_SUM, OP_SUB, OP_AND, OP_OR, OP_EOR, OP_SR, OP_ROR, OP_PASS
  } alu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic logic is_shift(alu_op_t op);
    return op == OP_SR || op == OP_ROR;
  endfunction
endpackage

// File: rtl/alu_lane.sv
// alu_lane: combinational one-byte ALU slice with BCD correction and carry/shift-bit chaining
module alu_lane
  import alu_seq_pkg::*;
(
  input  alu_op_t           i_op,
  input  logic              i_dec,
  input  logic              i_ci,
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_y,
  output logic              o_co,
  output logic              o_v
);
  logic              w_sub;
  logic              w_arith;
  logic [LANE_W-1:0] w_b;
  logic [LANE_W:0]   w_bin;
  logic [4:0]        w_lo;
  logic [4:0]        w_hi;
  logic              w_lc;
  logic              w_dco;
  logic [3:0]        w_dlo;
  logic [3:0]        w_dhi;
  // SUB reuses the adder with ~b; carry out of a nibble means "no borrow"
  always_comb begin
    w_sub   = i_op == OP_SUB;
    w_arith = i_op == OP_SUM || w_sub;
    w_b     = w_sub ? ~i_b : i_b;
    w_bin   = {1'b0, i_a} + {1'b0, w_b} + {{LANE_W{1'b0}}, i_ci};
    w_lo    = {1'b0, i_a[3:0]} + {1'b0, w_b[3:0]} + {4'b0, i_ci};
    w_lc    = w_sub ? w_lo[4] : (w_lo > 5'd9);
    w_dlo   = w_sub ? (w_lo[4] ? w_lo[3:0] : w_lo[3:0] - 4'd6)
                    : (w_lc ? w_lo[3:0] + 4'd6 : w_lo[3:0]);
    w_hi    = {1'b0, i_a[7:4]} + {1'b0, w_b[7:4]} + {4'b0, w_lc};
    w_dco   = w_sub ? w_hi[4] : (w_hi > 5'd9);
    w_dhi   = w_sub ? (w_hi[4] ? w_hi[3:0] : w_hi[3:0] - 4'd6)
                    : (w_dco ? w_hi[3:0] + 4'd6 : w_hi[3:0]);
    o_v     = (i_a[LANE_W-1] == w_b[LANE_W-1]) && (w_bin[LANE_W-1] != i_a[LANE_W-1]);
    o_y     = w_arith ? (i_dec ? {w_dhi, w_dlo} : w_bin[LANE_W-1:0])
            : i_op == OP_AND ? i_a & i_b
            : i_op == OP_OR  ? i_a | i_b
            : i_op == OP_EOR ? i_a ^ i_b
            : is_shift(i_op) ? {i_ci, i_a[LANE_W-1:1]}
            : i_a;
    o_co    = w_arith ? (i_dec ? w_dco : w_bin[LANE_W])
            : is_shift(i_op) ? i_a[0]
            : i_ci;
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-byte sequential ALU processing one 8-bit lane per ready cycle
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter bit DEC_EN = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic                     dec,
  input  logic                     cin,
  input  logic [LANE_W*NBYTES-1:0] a,
  input  logic [LANE_W*NBYTES-1:0] b,
  input  logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [LANE_W*NBYTES-1:0] result,
  output logic                     cout,
  output logic                     zf,
  output logic                     nf,
  output logic                     vf
);
  localparam int W = LANE_W * NBYTES;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  state_t            r_state;
  state_t            w_next;
  alu_op_t           r_op;
  logic              r_dec;
  logic              r_carry;
  logic              r_cout;
  logic              r_vf;
  logic [CW-1:0]     r_cnt;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_res;
  logic [CW-1:0]     w_idx;
  logic              w_last;
  logic              w_step;
  logic [LANE_W-1:0] w_y;
  logic              w_co;
  logic              w_v;
  // shifts walk from the top lane down so the shifted-out bit chains like a carry
  always_comb begin
    w_idx  = is_shift(r_op) ? LAST - r_cnt : r_cnt;
    w_last = r_cnt == LAST;
    w_step = r_state == S_RUN && ready;
    w_next = r_state == S_IDLE ? (start ? S_RUN : S_IDLE)
           : r_state == S_RUN  ? (w_step && w_last ? S_DONE : S_RUN)
           : S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RES) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_op    <= OP_SUM;
      r_dec   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_vf    <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_op    <= alu_op_t'(op);
      r_dec   <= dec & DEC_EN;
      r_carry <= alu_op_t'(op) == OP_SR ? 1'b0 : cin;
      r_cnt   <= '0;
      r_a     <= a;
      r_b     <= b;
    end else if (w_step) begin
      r_res[w_idx*LANE_W +: LANE_W] <= w_y;
      r_carry <= w_co;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_co;
        r_vf   <= (r_op == OP_SUM || r_op == OP_SUB) && w_v;
      end
    end
  end
  alu_lane u_lane (
    .i_op  (r_op),
    .i_dec (r_dec),
    .i_ci  (r_carry),
    .i_a   (r_a[w_idx*LANE_W +: LANE_W]),
    .i_b   (r_b[w_idx*LANE_W +: LANE_W]),
    .o_y   (w_y),
    .o_co  (w_co),
    .o_v   (w_v)
  );
  assign busy   = r_state == S_RUN;
  assign done   = r_state == S_DONE;
  assign result = r_res;
  assign cout   = r_cout;
  assign zf     = r_res == '0;
  assign nf     = r_res[W-1];
  assign vf     = r_vf;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq against a whole-word arithmetic reference model
module tb_alu_seq;
  localparam int N = 2;
  localparam int W = 8 * N;
  logic CLK = 1'b0;
  logic RES, start, dec, cin, ready;
  logic [2:0] op;
  logic [W-1:0] a, b, result;
  logic busy, done, cout, zf, nf, vf;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int s_cyc = 0;
  typedef struct {
    logic [W-1:0] res;
    logic cout, zf, nf, vf;
    int lat;
  } exp_t;
  exp_t q[$];
  alu_seq #(.NBYTES(N), .DEC_EN(1'b1)) dut (
    .CLK(CLK), .RES(RES), .start(start), .op(op), .dec(dec), .cin(cin),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .result(result),
    .cout(cout), .zf(zf), .nf(nf), .vf(vf)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = 2 * N - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction
  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < 2 * N; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  // decimal ops are modelled as integer add/subtract on decoded digit strings
  function automatic exp_t model(input int o, input bit d, input bit c,
                                 input logic [W-1:0] x, input logic [W-1:0] y, input int lat);
    exp_t e;
    logic [W:0] s;
    logic [W-1:0] yy;
    logic [7:0] xt, yt;
    logic [8:0] st;
    longint X, Y, M, Ml, t;
    bit cl;
    e.res = x; e.cout = c; e.vf = 1'b0; e.lat = lat;
    yy = (o == 1) ? ~y : y;
    if (o < 2 && !d) begin
      s = {1'b0, x} + {1'b0, yy} + (W+1)'(c);
      e.res = s[W-1:0];
      e.cout = s[W];
      e.vf = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    end else if (o < 2) begin
      X = bcd2int(x); Y = bcd2int(y);
      M = 10 ** (2 * N); Ml = 10 ** (2 * N - 2);
      if (o == 0) begin
        t = X + Y + longint'(c);
        cl = (X % Ml + Y % Ml + longint'(c)) >= Ml;
        e.cout = t >= M;
        e.res = int2bcd(t % M);
      end else begin
        t = X - Y - (1 - longint'(c));
        cl = (X % Ml - Y % Ml - (1 - longint'(c))) >= 0;
        e.cout = t >= 0;
        e.res = int2bcd(t < 0 ? t + M : t);
      end
      xt = x[W-1 -: 8]; yt = yy[W-1 -: 8];
      st = {1'b0, xt} + {1'b0, yt} + 9'(cl);
      e.vf = (xt[7] == yt[7]) && (st[7] != xt[7]);
    end else begin
      case (o)
        2: e.res = x & y;
        3: e.res = x | y;
        4: e.res = x ^ y;
        5: begin e.res = x >> 1; e.cout = x[0]; end
        6: begin e.res = {c, x[W-1:1]}; e.cout = x[0]; end
        default: e.res = x;
      endcase
    end
    e.zf = e.res == '0;
    e.nf = e.res[W-1];
    return e;
  endfunction
  task automatic issue(input int o, input bit d, input bit c, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int stall, input bit junk);
    bit seen = 1'b0;
    q.push_back(model(o, d, c, x, y, N + 1 + stall));
    @(posedge CLK); #1;
    start = 1'b1; op = 3'(o); dec = d; cin = c; a = x; b = y; s_cyc = cyc;
    @(posedge CLK); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = ~c;
    @(posedge CLK); #1;
    if (stall > 0) begin
      ready = 1'b0;
      if (junk) begin
        start = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      end
      repeat (stall) @(posedge CLK);
      #1 ready = 1'b1; start = 1'b0;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      seen = done;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout waiting for done op=%0d", o);
      if (q.size() > 0) q.delete(0);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected done result=%h", result);
        end else begin
          e = q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("cout", 32'(cout), 32'(e.cout));
          chk("zf", 32'(zf), 32'(e.zf));
          chk("nf", 32'(nf), 32'(e.nf));
          chk("vf", 32'(vf), 32'(e.vf));
          chk("latency", 32'(cyc - s_cyc), 32'(e.lat));
        end
      end
    end
  end
  initial begin
    logic [W-1:0] x, y;
    int o;
    bit d;
    RES = 1'b1; start = 1'b0; op = '0; dec = 1'b0; cin = 1'b0; ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge CLK);
    #1 RES = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", 32'(result), 0);
    chk("reset cout", 32'(cout), 0);
    chk("reset zf", 32'(zf), 1);
    chk("reset nf", 32'(nf), 0);
    chk("reset vf", 32'(vf), 0);
    issue(0, 0, 0, 16'h12FF, 16'h0001, 0, 0);
    issue(0, 0, 0, 16'h7FFF, 16'h0001, 0, 0);
    issue(1, 1, 1, 16'h0100, 16'h0001, 0, 0);
    issue(1, 1, 1, 16'h0100, 16'h0200, 0, 0);
    issue(6, 0, 1, 16'h0001, 16'h0000, 0, 0);
    issue(5, 0, 1, 16'h0001, 16'h0000, 0, 0);
    issue(0, 0, 0, 16'h12FF, 16'h0001, 3, 1);
    issue(0, 1, 1, 16'h9999, 16'h0001, 0, 0);
    issue(1, 0, 1, 16'h8000, 16'h0001, 0, 0);
    @(posedge CLK); #1;
    start = 1'b1; op = 3'd0; dec = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h1111;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    ready = 1'b0; RES = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    RES = 1'b0; start = 1'b0; ready = 1'b1;
    chk("midrun reset busy", 32'(busy), 0);
    chk("midrun reset done", 32'(done), 0);
    chk("midrun reset result", 32'(result), 0);
    chk("midrun reset zf", 32'(zf), 1);
    chk("midrun reset cout", 32'(cout), 0);
    issue(2, 0, 1, 16'hF0F0, 16'h3C3C, 0, 0);
    for (int k = 0; k < 60; k++) begin
      o = int'($urandom_range(0, 7));
      d = 1'($urandom_range(0, 1));
      x = W'($urandom);
      y = W'($urandom);
      if (o < 2 && d) begin
        for (int i = 0; i < 2 * N; i++) begin
          x[i*4 +: 4] = 4'($urandom_range(0, 9));
          y[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
      end
      issue(o, d, 1'($urandom_range(0, 1)), x, y, int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)));
    end
    repeat (4) @(posedge CLK);
    #1 chk("scoreboard drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 2, number of 8-bit lanes per operand (legal range 1..8).
REQ-002 SHALL have parameter DEC_EN, default 1, which enables decimal correction when set to 1.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RES  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request: capture operands and begin an operation.
REQ-006 op  in  3  0 SUM, 1 SUB, 2 AND, 3 OR, 4 EOR, 5 SR, 6 ROR, 7 PASS.
REQ-007 dec  in  1  decimal mode for SUM/SUB; ignored if DEC_EN=0.
REQ-008 cin  in  1  carry in (SUB: 1 = no borrow).
REQ-009 a, b  in  8*NBYTES  operands.
REQ-010 ready  in  1  lane-advance enable; 0 freezes all state.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 result  out  8*NBYTES  registered result.
REQ-014 cout, zf, nf, vf  out  1 each  carry, zero, negative and overflow flags.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 IDLE with start=1 SHALL latch op/dec/cin/a/b, clear the lane counter, and enter RUN; busy rises next cycle.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 RUN SHALL process one lane per cycle with ready=1; ready=0 SHALL hold counter, carry and partial result.
REQ-019 SUM/SUB/AND/OR/EOR/PASS SHALL process lane 0 (LSB) first; SR/ROR SHALL process lane NBYTES-1 first.
REQ-020 SUM lane = a+b+carry; SUB lane = a+~b+carry; each lane's carry-out feeds the next lane, and the first lane uses cin.
REQ-021 SR SHALL shift right with 0 into the result MSB; ROR SHALL shift in cin; the bit shifted out of each lane's LSB feeds the next lower lane's MSB; cout = final bit shifted out.
REQ-022 AND/OR/EOR/PASS SHALL leave cout = cin; PASS result = a.
REQ-023 With dec=1 and DEC_EN=1, SUM SHALL add 6 to a nibble when the nibble exceeds 9 or the nibble carries; the adjusted carry propagates.
REQ-024 With dec=1 and DEC_EN=1, SUB SHALL subtract 6 from a nibble when that nibble borrows.
REQ-025 After the last lane the FSM SHALL enter DONE: done=1 for exactly one cycle, and result/flags are valid from that cycle until the next start.
REQ-026 Latency SHALL be start cycle + NBYTES + 1 to done with ready held at 1.
REQ-027 zf = (result==0); nf = result MSB.
REQ-028 vf SHALL be the binary signed overflow of the top lane for SUM/SUB and 0 for all other ops.
REQ-029 NBYTES=1 SHALL take one RUN cycle with no cross-lane chaining.

Reset
REQ-030 RES=1 SHALL force IDLE next edge in any state, including mid-RUN with ready=0.
REQ-031 Reset values SHALL be busy=0, done=0, result=0, cout=0, zf=1, nf=0, vf=0, lane counter=0.
REQ-032 RES SHALL take priority over start and ready.

Structure
REQ-033 The op encoding (alu_op_t), the FSM state enum and LANE_W=8 SHALL live in the shared core package.
REQ-034 The per-lane datapath SHALL be one sub-module, alu_lane, which is combinational and performs one op per lane including BCD and carry/shift-bit chaining; alu_seq owns the FSM, counter and registers.

Verification (NBYTES=2)
REQ-035 SUM a=0x12FF, b=0x0001, cin=0 -> result 0x1300, cout=0, zf=0, done 3 cycles after start.
REQ-036 SUM a=0x7FFF, b=0x0001, cin=0 -> result 0x8000, vf=1, nf=1, cout=0.
REQ-037 SUB dec=1, a=0x0100, b=0x0001, cin=1 -> result 0x0099, cout=1; repeat with b=0x0200 -> 0x9900, cout=0.
REQ-038 ROR a=0x0001, cin=1 -> result 0x8000, cout=1; SR same operands -> 0x0000, zf=1, cout=1.
REQ-039 SUM with ready=0 for 3 cycles after the first lane -> done at cycle 6, result identical to the unstalled run; start pulsed while busy is ignored.
REQ-040 RES pulsed in RUN -> next cycle busy=0, done=0, result=0, zf=1; a subsequent start runs normally.
